// File: rtl/arbitrated_mux_pkg.sv
// mux_pkg: shared select-mode encoding for arbitrated_mux and its testbench
package mux_pkg;
   typedef enum logic {MODE_FIXED = 1'b0, MODE_RR = 1'b1} mode_e;
endpackage

// File: rtl/arbitrated_mux_if.sv
// arbitrated_mux_if: producer/consumer bundle for arbitrated_mux
//   mode, address       select control (fixed index or round-robin)
//   in_valid/in_ready   per-channel input handshake, in_data flattened per channel
//   out_valid/out_ready output handshake, out_data/out_channel registered word and its source
//   master = environment side, slave = mux side
interface arbitrated_mux_if
   import mux_pkg::*;
#(
   parameter int WIDTH    = 1,
   parameter int CHANNELS = 4,
   parameter int ADDR_W   = $clog2(CHANNELS)
);
   mode_e                     mode;
   logic [ADDR_W-1:0]         address;
   logic [CHANNELS-1:0]       in_valid;
   logic [CHANNELS-1:0]       in_ready;
   logic [CHANNELS*WIDTH-1:0] in_data;
   logic                      out_valid;
   logic                      out_ready;
   logic [WIDTH-1:0]          out_data;
   logic [ADDR_W-1:0]         out_channel;
   modport master (output mode, address, in_valid, in_data, out_ready,
                   input  in_ready, out_valid, out_data, out_channel);
   modport slave  (input  mode, address, in_valid, in_data, out_ready,
                   output in_ready, out_valid, out_data, out_channel);
endinterface

// File: rtl/arbitrated_mux_rr_priority_pick.sv
// rr_priority_pick: first valid channel at or after i_ptr, wrapping past CHANNELS-1
//   i_valid  per-channel valid vector
//   i_ptr    channel the search starts from
//   o_g      picked channel index
//   o_gv     high when any channel is valid
module rr_priority_pick #(
   parameter int CHANNELS = 4,
   parameter int ADDR_W   = $clog2(CHANNELS)
) (
   input  logic [CHANNELS-1:0] i_valid,
   input  logic [ADDR_W-1:0]   i_ptr,
   output logic [ADDR_W-1:0]   o_g,
   output logic                o_gv
);
   // Scan from the farthest offset down so the nearest valid channel overwrites last.
   always_comb begin
      o_g  = '0;
      o_gv = 1'b0;
      for (int k = CHANNELS - 1; k >= 0; k--) begin
         int idx;
         idx = int'(i_ptr) + k;
         idx = (idx >= CHANNELS) ? idx - CHANNELS : idx;
         if (i_valid[idx]) begin
            o_g  = ADDR_W'(idx);
            o_gv = 1'b1;
         end
      end
   end
endmodule

// File: rtl/arbitrated_mux.sv
// arbitrated_mux: CHANNELS-to-1 stream mux, fixed or round-robin select, registered output
//   clk     rising-edge clock
//   reset   synchronous active-high reset
//   io_bus  arbitrated_mux_if slave: select control, input and output handshakes
module arbitrated_mux
   import mux_pkg::*;
#(
   parameter int WIDTH    = 1,
   parameter int CHANNELS = 4,
   parameter int ADDR_W   = $clog2(CHANNELS)
) (
   input logic               clk,
   input logic               reset,
   arbitrated_mux_if.slave   io_bus
);
   typedef logic [ADDR_W-1:0] chan_idx_t;
   chan_idx_t           r_ptr;
   chan_idx_t           r_channel;
   logic                r_valid;
   logic [WIDTH-1:0]    r_data;
   chan_idx_t           w_rr_g;
   logic                w_rr_gv;
   chan_idx_t           w_g;
   logic                w_gv;
   logic                w_fix_gv;
   logic                w_slot_free;
   logic                w_accept;
   logic [CHANNELS-1:0] w_ready;
   logic [WIDTH-1:0]    w_data;
   rr_priority_pick #(.CHANNELS(CHANNELS), .ADDR_W(ADDR_W)) u_pick (
      .i_valid (io_bus.in_valid),
      .i_ptr   (r_ptr),
      .o_g     (w_rr_g),
      .o_gv    (w_rr_gv)
   );
   // Out-of-range addresses match no channel, so fixed mode never grants them.
   always_comb begin
      w_fix_gv = 1'b0;
      for (int i = 0; i < CHANNELS; i++)
         if (io_bus.address == chan_idx_t'(i)) w_fix_gv = io_bus.in_valid[i];
   end
   assign w_slot_free = !r_valid || io_bus.out_ready;
   assign w_g         = (io_bus.mode == MODE_RR) ? w_rr_g : io_bus.address;
   assign w_gv        = (io_bus.mode == MODE_RR) ? w_rr_gv : w_fix_gv;
   assign w_accept    = w_gv && w_slot_free;
   // Data is picked by decoded grant so unselected channels (even X) never propagate.
   always_comb begin
      w_ready = '0;
      w_data  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_ready[i] = w_accept && (w_g == chan_idx_t'(i));
         if (w_g == chan_idx_t'(i)) w_data = io_bus.in_data[i*WIDTH +: WIDTH];
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid   <= 1'b0;
         r_data    <= '0;
         r_channel <= '0;
         r_ptr     <= '0;
      end else begin
         if (w_accept) begin
            r_valid   <= 1'b1;
            r_data    <= w_data;
            r_channel <= w_g;
         end else if (io_bus.out_ready) begin
            r_valid   <= 1'b0;
         end
         if (w_accept && io_bus.mode == MODE_RR)
            r_ptr <= (w_g == chan_idx_t'(CHANNELS - 1)) ? '0 : w_g + 1'b1;
      end
   end
   assign io_bus.in_ready    = w_ready;
   assign io_bus.out_valid   = r_valid;
   assign io_bus.out_data    = r_data;
   assign io_bus.out_channel = r_channel;
endmodule
